// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns
// (bit7=a .. bit1=g, bit0=dp, active-high) and the scan FSM state type.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to 7-segment decoder; non-BCD codes (10..15) render blank.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered display value.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Handshake: a transfer happens on a rising edge where upd_valid && upd_ready;
    // upd_valid while upd_ready is low is ignored and upd_data may change freely.
    input  logic                  upd_valid,
    input  logic [4*DIGITS-1:0]   upd_data,
    output logic                  upd_ready,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [DIGITS-1:0]     cat,
    output logic [7:0]            signal,
    output logic                  frame_done,
    output state_t                dbg_state_o
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = $clog2(DIGITS);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [DIGITS-1:0]     cat_q, cat_d;
    logic [7:0]            signal_q, signal_d;
    logic                  frame_done_q, frame_done_d;
    logic                  upd_ready_q, upd_ready_d;

    logic                  commit;
    logic                  xfer;
    logic [4*DIGITS-1:0]   active_shifted;
    logic [3:0]            nibble;
    logic [7:0]            seg_pat;
    logic                  digit_vis;

    // Slot sequencing: BLANK dead-time, then DWELL cycles of one digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        commit  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IW'(DIGITS - 1)) begin
                        idx_d  = '0;
                        commit = 1'b1;
                    end else begin
                        idx_d  = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Shadow/active buffering; the active value only moves at frame end.
    always_comb begin
        xfer      = upd_valid && !pending_q;
        shadow_d  = xfer ? upd_data : shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (commit && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (xfer) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are computed from next-state values so the registered
    // cat/signal line up with the registered FSM state.
    always_comb begin
        active_shifted = active_q >> {idx_d, 2'b00};
        nibble         = active_shifted[3:0];
    end

    seg_decoder u_decoder (
        .bcd_i (nibble),
        .seg_o (seg_pat)
    );

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] lzb_blank;
    logic              lead_zero;

    // A digit is blanked when it and every more significant nibble are zero.
    always_comb begin
        lzb_blank = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_zero    = lead_zero && (active_q[4*i +: 4] == 4'd0);
            lzb_blank[i] = lead_zero;
        end
        digit_vis = digit_en[idx_d] && !lzb_blank[idx_d];
    end
`else
    always_comb begin
        digit_vis = digit_en[idx_d];
    end
`endif

    always_comb begin
        cat_d        = '0;
        signal_d     = SEG_BLANK;
        if ((state_d == ST_SCAN) && digit_vis) begin
            cat_d    = DIGITS'(1) << idx_d;
            signal_d = seg_pat;
        end
        frame_done_d = commit;
        upd_ready_d  = !pending_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            cat_q        <= '0;
            signal_q     <= SEG_BLANK;
            frame_done_q <= 1'b0;
            upd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            cat_q        <= cat_d;
            signal_q     <= signal_d;
            frame_done_q <= frame_done_d;
            upd_ready_q  <= upd_ready_d;
        end
    end

    assign cat         = cat_q;
    assign signal      = signal_q;
    assign frame_done  = frame_done_q;
    assign upd_ready   = upd_ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=2, DWELL=4, BLANK=1): directed steps plus
// randomized updates, compared every cycle against a frame-position model.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int DIGITS = 2;
    localparam int DWELL  = 4;
    localparam int BLANK  = 1;
    localparam int SLOT   = DWELL + BLANK;
    localparam int FRAME  = DIGITS * SLOT;

    logic         clk;
    logic         rst_n;
    logic         upd_valid;
    logic [7:0]   upd_data;
    logic         upd_ready;
    logic [1:0]   digit_en;
    logic [1:0]   cat;
    logic [7:0]   signal;
    logic         frame_done;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           t;
    logic [7:0]   m_active;
    logic [7:0]   m_shadow;
    bit           m_pending;
    logic [1:0]   en_prev;

    seg_scan_ctrl #(
        .DIGITS (DIGITS),
        .DWELL  (DWELL),
        .BLANK  (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_data    (upd_data),
        .upd_ready   (upd_ready),
        .digit_en    (digit_en),
        .cat         (cat),
        .signal      (signal),
        .frame_done  (frame_done),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 8'hFC;
            4'd1: return 8'h60;
            4'd2: return 8'hDA;
            4'd3: return 8'hF2;
            4'd4: return 8'h66;
            4'd5: return 8'hB6;
            4'd6: return 8'hBE;
            4'd7: return 8'hE0;
            4'd8: return 8'hFE;
            4'd9: return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Compare all outputs against the model for frame cycle t.
    task automatic check_outputs();
        int p, s, o;
        bit vis;
        logic [1:0] e_cat;
        logic [7:0] e_sig;
        logic [7:0] upper;
        p = t % FRAME;
        s = p / SLOT;
        o = p % SLOT;
        vis = (o >= BLANK) && en_prev[s];
`ifdef SEG_LZB_EN
        upper = m_active >> (4 * s);
        if (s > 0 && upper == 8'h00) vis = 0;
`endif
        e_cat = vis ? (2'b01 << s) : 2'b00;
        e_sig = vis ? dec(4'((m_active >> (4 * s)) & 8'h0F)) : 8'h00;
        chk("cat", 32'(cat), 32'(e_cat));
        chk("signal", 32'(signal), 32'(e_sig));
        chk("frame_done", 32'(frame_done), 32'((p == 0 && t > 0) ? 1 : 0));
        chk("upd_ready", 32'(upd_ready), 32'(m_pending ? 0 : 1));
        chk("state", 32'(dbg_state), 32'((o < BLANK) ? ST_BLANK : ST_SCAN));
    endtask

    // One cycle: check at negedge, drive, advance model at posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] en);
        bit xfer;
        bit commit;
        check_outputs();
        upd_valid = v;
        upd_data  = d;
        digit_en  = en;
        @(posedge clk);
        xfer   = v && !m_pending;
        commit = ((t % FRAME) == FRAME - 1);
        if (commit && m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (xfer) begin
            m_shadow  = d;
            m_pending = 1;
        end
        en_prev = en;
        t++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        t         = 0;
        m_active  = 8'h00;
        m_shadow  = 8'h00;
        m_pending = 0;
    endtask

    initial begin
        logic [1:0] en;
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        upd_data  = 8'h00;
        digit_en  = 2'b11;
        en_prev   = 2'b11;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two idle frames showing "00"
        repeat (2 * FRAME) step(1'b0, 8'h00, 2'b11);

        // Mid-frame transfer of 0x19, then a refused 0x07 while pending
        repeat (3) step(1'b0, 8'h00, 2'b11);
        step(1'b1, 8'h19, 2'b11);
        step(1'b1, 8'h07, 2'b11);
        repeat (3 * FRAME) step(1'b0, 8'hAA, 2'b11);

        // Tens digit disabled
        repeat (2 * FRAME) step(1'b0, 8'h00, 2'b01);

        // Leading-zero cases
        while (t % FRAME != 2) step(1'b0, 8'h00, 2'b11);
        step(1'b1, 8'h05, 2'b11);
        repeat (2 * FRAME) step(1'b0, 8'h00, 2'b11);
        step(1'b1, 8'h00, 2'b11);
        repeat (2 * FRAME) step(1'b0, 8'h00, 2'b11);

        // Randomized updates and enables
        en = 2'b11;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) en = 2'($urandom_range(0, 3));
            step($urandom_range(0, 6) == 0, 8'($urandom), en);
        end

        // Reset during the tens slot with an update pending
        while (t % FRAME != 0) step(1'b0, 8'h00, 2'b11);
        step(1'b0, 8'h00, 2'b11);
        step(1'b1, 8'h37, 2'b11);
        while (t % FRAME != 7) step(1'b0, 8'h00, 2'b11);
        check_outputs();
        chk("pending_before_reset", 32'(upd_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("rst_cat", 32'(cat), 32'(0));
        chk("rst_signal", 32'(signal), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_state", 32'(dbg_state), 32'(ST_BLANK));
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (3 * FRAME) step(1'b0, 8'h00, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8, sets the number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter DWELL, default 1000, sets the clk cycles each digit is driven per slot (>=2).
REQ-003 Parameter BLANK, default 4, sets the dead-time clk cycles between slots with all digits off (>=1).
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 upd_valid  input  1  new display value offered.
REQ-007 upd_data  input  4*DIGITS  BCD nibbles; nibble 0 (bits 3:0) is the least significant digit.
REQ-008 upd_ready  output  1  controller can accept upd_data this cycle.
REQ-009 digit_en  input  DIGITS  per-digit enable, sampled live.
REQ-010 cat  output  DIGITS  one-hot active-high digit select.
REQ-011 signal  output  8  segment pattern, bit7=a .. bit1=g, bit0=dp, active-high.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states BLANK and SCAN, with a digit index idx (0..DIGITS-1) and a cycle counter.
REQ-015 BLANK SHALL hold cat=0 and signal=0 for exactly BLANK cycles, then enter SCAN.
REQ-016 SCAN SHALL hold for exactly DWELL cycles: cat = one-hot(idx) and signal = decode(active nibble idx).
REQ-017 On leaving SCAN, idx SHALL increment, wrapping DIGITS-1 -> 0, and the FSM SHALL enter BLANK.
REQ-018 The frame period SHALL be DIGITS*(DWELL+BLANK) cycles, independent of digit_en.
REQ-019 A digit with digit_en[idx]=0 SHALL still consume its slot, with cat=0 and signal=0.
REQ-020 Decode: 0..9 -> standard patterns (0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 hex); 10..15 -> 00; dp always 0.
REQ-021 Updates SHALL be double-buffered; a transfer (upd_valid && upd_ready) captures upd_data into a shadow register and sets pending.
REQ-022 upd_ready SHALL be !pending.
REQ-023 In the last SCAN cycle of idx=DIGITS-1 the active register SHALL load the shadow if pending, pending SHALL clear, and frame_done SHALL pulse next cycle.
REQ-024 No display tearing: the active value SHALL change only at a frame boundary.
REQ-025 A transfer in the commit cycle is impossible, because upd_ready is 0 whenever pending; with no pending data, a transfer in that cycle SHALL be committed at the next frame end.
REQ-026 upd_valid without upd_ready SHALL be ignored; upd_data need not be held stable.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=BLANK, idx=0, counter=0, cat=0, signal=0, frame_done=0, pending=0, upd_ready=1 after release, active and shadow registers = all zero (display "0...0").
REQ-028 Reset mid-slot or mid-frame SHALL discard any pending update; scanning SHALL restart from BLANK with idx=0 on the first clk after release.

Configuration
REQ-029 With macro SEG_LZB_EN defined, leading-zero blanking SHALL apply: zero nibbles from idx DIGITS-1 downward up to the first nonzero nibble show cat=0 and signal=0; idx 0 is never blanked.
REQ-030 Without SEG_LZB_EN, every enabled digit SHALL be displayed, including leading zeros; no blanking logic is present.

Structure
REQ-031 Package seg_pkg SHALL hold the segment pattern constants (digits 0-9, blank) and the FSM state typedef.
REQ-032 Sub-module seg_decoder (4-bit BCD -> 8-bit pattern, combinational) SHALL be instantiated once, driven by a mux of the active nibble.

Verification (DIGITS=2, DWELL=4, BLANK=1)
REQ-033 Reset release -> cat=00 for 1 cycle, then cat=01 with signal=FC for 4 cycles, BLANK 1, cat=10 with signal=FC for 4 cycles; frame_done pulses every 10 cycles.
REQ-034 Transfer 0x19 mid-frame -> upd_ready=0 until the frame end; the next frame shows 60 on cat=10 and F6 on cat=01; the current frame is unchanged.
REQ-035 Second upd_valid with 0x07 while pending -> not accepted; the display shows 0x19 and upd_ready returns to 1 after commit.
REQ-036 digit_en=01 -> cat never equals 10; frame_done spacing stays 10 cycles.
REQ-037 SEG_LZB_EN, value 0x05 -> tens slot cat=00/signal=00, units B6; value 0x00 -> units shows FC.
REQ-038 rst_n pulsed low during the cat=10 slot with pending=1 -> outputs 0 immediately, pending cleared, display shows 00, scan restarts at idx 0.
